// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the dcache (port 0)
// and the icache (port 1); one transaction in flight, with a sticky missing-ack watchdog.
module mem_arbiter #(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              grant_o,
  output logic              busy_o,
  output logic              timeout_o
);

  // state | meaning
  // IDLE  | no transaction; arbitrate between requesting ports
  // BUSY  | transaction issued to memory, waiting for mem_ack_i
  // TURN  | one-cycle gap so memory sees a fresh enable edge
  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic             rr_ptr;
  logic             req_any;
  logic             win;
  logic             wd_hit;
  logic [CNT_W-1:0] wait_cnt;

  assign req_any = p0_enable_i | p1_enable_i;
  assign win     = (p0_enable_i & p1_enable_i) ? rr_ptr : p1_enable_i;
  assign wd_hit  = (TIMEOUT != 0) && (wait_cnt == WD_LAST);

  assign busy_o    = (state == BUSY);
  assign p0_ack_o  = mem_ack_i & busy_o & ~grant_o;
  assign p1_ack_o  = mem_ack_i & busy_o & grant_o;
  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = BUSY;
      BUSY:    if (mem_ack_i) state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr       <= 1'b0;
      grant_o      <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      timeout_o    <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            grant_o      <= win;
            mem_enable_o <= 1'b1;
            mem_write_o  <= win ? p1_write_i : p0_write_i;
            mem_addr_o   <= win ? p1_addr_i  : p0_addr_i;
            mem_data_o   <= win ? p1_data_i  : p0_data_i;
            wait_cnt     <= '0;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            rr_ptr       <= ~grant_o;
          end else begin
            if (wd_hit) timeout_o <= 1'b1;
            // saturate so a hung memory cannot wrap back onto the trip point
            if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table-driven arbitration vectors with a transaction scoreboard,
// plus hand-written fairness, writeback/refill, stray ack, watchdog and reset sequences.
module tb_mem_arbiter;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst_i;
  logic              p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
  logic [ADDR_W-1:0] p0_addr_i, p1_addr_i;
  logic [DATA_W-1:0] p0_data_i, p1_data_i;
  logic [DATA_W-1:0] p0_data_o, p1_data_o;
  logic              p0_ack_o, p1_ack_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o, mem_data_i;
  logic              mem_ack_i;
  logic              grant_o, busy_o, timeout_o;

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
    .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              port;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  typedef struct {
    logic              p0_en, p0_wr;
    logic [ADDR_W-1:0] p0_addr;
    logic              p1_en, p1_wr;
    logic [ADDR_W-1:0] p1_addr;
    int                delay;
    logic              first;
  } vec_t;

  localparam logic [DATA_W-1:0] IDLE_PAT = {8{32'hDEADBEEF}};

  txn_t exp_q[$];
  txn_t cur;
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   ack_delay = 0;
  int   mdl_cnt = 0;
  int   low_cnt = 0;
  logic stray_req = 1'b0;
  logic in_flight = 1'b0;
  logic prev_en = 1'b0;
  logic had_ack = 1'b0;
  logic ack0_seen = 1'b0;
  logic ack1_seen = 1'b0;

  function automatic logic [DATA_W-1:0] rd_fn(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'h5A5A0000}};
  endfunction

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic [7:0] tag);
    return {8{tag, a[23:0]}};
  endfunction

  function automatic vec_t mkvec(input logic e0, input logic w0, input logic [31:0] a0,
                                 input logic e1, input logic w1, input logic [31:0] a1,
                                 input int d, input logic f);
    vec_t v;
    v.p0_en = e0; v.p0_wr = w0; v.p0_addr = a0;
    v.p1_en = e1; v.p1_wr = w1; v.p1_addr = a1;
    v.delay = d;  v.first = f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic port, input logic wr, input logic [31:0] addr,
                      input logic [DATA_W-1:0] data);
    txn_t t;
    t.port = port; t.wr = wr; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endtask

  // One clock: memory model acts on the falling edge, checks run just after it.
  task automatic tick();
    logic e0, e1;
    @(negedge clk);
    if (rst_i) begin
      mem_ack_i = 1'b0; mdl_cnt = 0;
    end else if (mem_ack_i) begin
      mem_ack_i = 1'b0; mdl_cnt = 0; mem_data_i = IDLE_PAT;
    end else if (stray_req) begin
      mem_ack_i = 1'b1; stray_req = 1'b0; mem_data_i = rd_fn(32'h0000FFFF);
    end else if (mem_enable_o) begin
      mdl_cnt++;
      if (mdl_cnt == ack_delay) begin
        mem_ack_i = 1'b1; mem_data_i = rd_fn(mem_addr_o);
      end
    end else begin
      mdl_cnt = 0;
    end
    #1;
    ack0_seen = p0_ack_o;
    ack1_seen = p1_ack_o;
    if (mem_enable_o && !prev_en) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_grant actual=%0h expected=none", mem_addr_o);
      end else begin
        cur = exp_q.pop_front();
        chk("grant", grant_o, cur.port);
        chk("mem_addr", mem_addr_o, cur.addr);
        chk("mem_write", mem_write_o, cur.wr);
        chk("mem_data", mem_data_o, cur.data);
        if (had_ack) chk("turn_gap_ge2", low_cnt >= 2, 1'b1);
        in_flight = 1'b1;
      end
      low_cnt = 0;
    end
    if (!mem_enable_o) low_cnt++;
    e0 = mem_ack_i && in_flight && !cur.port;
    e1 = mem_ack_i && in_flight && cur.port;
    chk("busy", busy_o, in_flight);
    chk("p0_ack", p0_ack_o, e0);
    chk("p1_ack", p1_ack_o, e1);
    if (mem_ack_i && in_flight) begin
      if (cur.port) chk("p1_data", p1_data_o, rd_fn(cur.addr));
      else          chk("p0_data", p0_data_o, rd_fn(cur.addr));
      in_flight = 1'b0;
      had_ack   = 1'b1;
      low_cnt   = 0;
    end
    prev_en = mem_enable_o;
  endtask

  task automatic wait_ack(input logic port, input int budget);
    int n = 0;
    while (!(port ? ack1_seen : ack0_seen) && n < budget) begin
      tick();
      n++;
    end
    chk(port ? "wait_ack1" : "wait_ack0", port ? ack1_seen : ack0_seen, 1'b1);
  endtask

  task automatic do_reset();
    p0_enable_i = 1'b0; p1_enable_i = 1'b0;
    rst_i = 1'b1;
    in_flight = 1'b0; prev_en = 1'b0; had_ack = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int got, need;
    need = int'(v.p0_en) + int'(v.p1_en);
    got = 0;
    ack_delay = v.delay;
    p0_enable_i = v.p0_en; p0_write_i = v.p0_wr; p0_addr_i = v.p0_addr;
    p0_data_i = pat(v.p0_addr, 8'h0D);
    p1_enable_i = v.p1_en; p1_write_i = v.p1_wr; p1_addr_i = v.p1_addr;
    p1_data_i = pat(v.p1_addr, 8'h0E);
    if (v.p0_en && v.p1_en) begin
      if (v.first) begin
        push(1'b1, v.p1_wr, v.p1_addr, p1_data_i);
        push(1'b0, v.p0_wr, v.p0_addr, p0_data_i);
      end else begin
        push(1'b0, v.p0_wr, v.p0_addr, p0_data_i);
        push(1'b1, v.p1_wr, v.p1_addr, p1_data_i);
      end
    end else if (v.p0_en) begin
      push(1'b0, v.p0_wr, v.p0_addr, p0_data_i);
    end else begin
      push(1'b1, v.p1_wr, v.p1_addr, p1_data_i);
    end
    tick();
    chk("grant_latency", mem_enable_o, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (ack0_seen) begin got++; p0_enable_i = 1'b0; end
      if (ack1_seen) begin got++; p1_enable_i = 1'b0; end
      if (got >= need) break;
      tick();
    end
    chk("vec_acks", got, need);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int n0, n1;
    rst_i = 1'b1;
    p0_enable_i = 0; p0_write_i = 0; p0_addr_i = '0; p0_data_i = '0;
    p1_enable_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
    mem_ack_i = 0; mem_data_i = IDLE_PAT;

    vecs[0] = mkvec(1, 0, 32'h100,  1, 0, 32'h200,  3, 0);
    vecs[1] = mkvec(1, 0, 32'h400,  0, 0, 32'h0,   10, 0);
    vecs[2] = mkvec(0, 0, 32'h0,    1, 1, 32'h3000, 1, 1);
    vecs[3] = mkvec(1, 1, 32'h40,   1, 0, 32'h80,   2, 0);
    vecs[4] = mkvec(0, 0, 32'h0,    1, 0, 32'h500,  5, 1);
    vecs[5] = mkvec(1, 1, 32'h600,  0, 0, 32'h0,    2, 0);
    vecs[6] = mkvec(1, 0, 32'h700,  1, 1, 32'h800,  4, 1);
    vecs[7] = mkvec(1, 1, 32'h900,  1, 0, 32'hA00,  1, 1);

    do_reset();
    chk("rst_enable", mem_enable_o, 1'b0);
    chk("rst_write", mem_write_o, 1'b0);
    chk("rst_addr", mem_addr_o, '0);
    chk("rst_data", mem_data_o, '0);
    chk("rst_grant", grant_o, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // fairness with both enables held: 0,1,0,1
    do_reset();
    ack_delay = 2;
    p0_write_i = 0; p0_addr_i = 32'h1000; p0_data_i = pat(32'h1000, 8'h0D);
    p1_write_i = 0; p1_addr_i = 32'h2000; p1_data_i = pat(32'h2000, 8'h0E);
    for (int i = 0; i < 2; i++) begin
      push(1'b0, 1'b0, 32'h1000, p0_data_i);
      push(1'b1, 1'b0, 32'h2000, p1_data_i);
    end
    p0_enable_i = 1; p1_enable_i = 1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 100 && (n0 + n1) < 4; i++) begin
      tick();
      if (ack0_seen) n0++;
      if (ack1_seen) n1++;
      if (n0 == 2) p0_enable_i = 0;
      if (n1 == 2) p1_enable_i = 0;
    end
    chk("fair_p0_acks", n0, 2);
    chk("fair_p1_acks", n1, 2);
    repeat (3) tick();

    // writeback then refill on port 0 with enable held
    ack_delay = 3;
    p0_enable_i = 1; p0_write_i = 1; p0_addr_i = 32'h1420; p0_data_i = {32{8'hA5}};
    push(1'b0, 1'b1, 32'h1420, {32{8'hA5}});
    push(1'b0, 1'b0, 32'h0420, '0);
    tick();
    chk("wb_enable", mem_enable_o, 1'b1);
    wait_ack(1'b0, 20);
    p0_write_i = 0; p0_addr_i = 32'h0420; p0_data_i = '0;
    tick();
    chk("wb_turn_en", mem_enable_o, 1'b0);
    chk("wb_write_clr", mem_write_o, 1'b0);
    tick();
    chk("wb_idle_en", mem_enable_o, 1'b0);
    tick();
    chk("refill_en", mem_enable_o, 1'b1);
    wait_ack(1'b0, 20);
    p0_enable_i = 0;
    repeat (3) tick();

    // ack with nothing in flight is ignored
    stray_req = 1'b1;
    repeat (3) tick();
    chk("stray_no_en", mem_enable_o, 1'b0);

    // watchdog: ack arrives late at cycle 80
    ack_delay = 80;
    p1_enable_i = 1; p1_write_i = 0; p1_addr_i = 32'h2240; p1_data_i = pat(32'h2240, 8'h0E);
    push(1'b1, 1'b0, 32'h2240, p1_data_i);
    tick();
    chk("wd_enable", mem_enable_o, 1'b1);
    repeat (63) tick();
    chk("wd_before", timeout_o, 1'b0);
    tick();
    chk("wd_set", timeout_o, 1'b1);
    chk("wd_busy", busy_o, 1'b1);
    wait_ack(1'b1, 40);
    p1_enable_i = 0;
    repeat (2) tick();
    chk("wd_sticky", timeout_o, 1'b1);

    // reset in the middle of a transaction, p1 pending
    ack_delay = 20;
    p0_enable_i = 1; p0_write_i = 1; p0_addr_i = 32'h700; p0_data_i = pat(32'h700, 8'h0D);
    push(1'b0, 1'b1, 32'h700, p0_data_i);
    tick();
    p1_enable_i = 1; p1_write_i = 0; p1_addr_i = 32'h900; p1_data_i = pat(32'h900, 8'h0E);
    repeat (4) tick();
    push(1'b1, 1'b0, 32'h900, p1_data_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_enable", mem_enable_o, 1'b0);
    chk("mid_rst_write", mem_write_o, 1'b0);
    chk("mid_rst_addr", mem_addr_o, '0);
    chk("mid_rst_data", mem_data_o, '0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_timeout", timeout_o, 1'b0);
    chk("mid_rst_acks", {p1_ack_o, p0_ack_o}, 2'b00);
    p0_enable_i = 0;
    in_flight = 1'b0; prev_en = 1'b0; had_ack = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    chk("rst_regrant_en", mem_enable_o, 1'b1);
    chk("rst_regrant_port", grant_o, 1'b1);
    wait_ack(1'b1, 60);
    p1_enable_i = 0;
    repeat (3) tick();

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 256-bit line-wide data memory port between two cache controllers.
- Port 0 is the dcache; port 1 is the icache.
- Each port uses the same enable/write/addr/data/ack protocol as the cache-to-memory interface.
- Round-robin arbitration; one transaction in flight; registered request capture; one-cycle turnaround between transactions; sticky watchdog on missing memory ack.

Parameters:
- DATA_W, 256, line width of the memory data buses.
- ADDR_W, 32, byte address width.
- TIMEOUT, 64, cycles from mem_enable_o rise to mem_ack_i before timeout_o sets; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- p0_enable_i  in  1  port 0 request; held high until its ack.
- p0_write_i  in  1  port 0 write (1) / read (0).
- p0_addr_i  in  ADDR_W  port 0 line address.
- p0_data_i  in  DATA_W  port 0 write data.
- p0_data_o  out  DATA_W  read data; equals mem_data_i.
- p0_ack_o  out  1  port 0 completion pulse.
- p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o  as port 0, for port 1.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  memory write.
- mem_addr_o  out  ADDR_W  memory address.
- mem_data_o  out  DATA_W  memory write data.
- mem_data_i  in  DATA_W  memory read data.
- mem_ack_i  in  1  memory completion pulse, one cycle.
- grant_o  out  1  port currently or last granted.
- busy_o  out  1  high in BUSY.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, rr_ptr=0 (port 0 preferred), grant_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, timeout_o=0, wait counter=0. Ack outputs are 0.
- A reset asserted mid-transaction abandons it with no ack; the requester must re-request.
- States: IDLE, BUSY, TURN.
- IDLE, no request: stay.
- IDLE, one port requesting: grant it.
- IDLE, both requesting: grant the port indicated by rr_ptr.
- On the grant edge:
  - capture the winner's write/addr/data into mem_write_o/mem_addr_o/mem_data_o;
  - set mem_enable_o=1, grant_o=winner, clear wait counter;
  - go to BUSY.
- Latency: request seen in cycle N gives mem_enable_o=1 in cycle N+1.
- BUSY:
  - mem_* outputs are held constant; requester input changes are ignored.
  - The wait counter increments each cycle without ack.
  - When counter==TIMEOUT-1 and TIMEOUT!=0, timeout_o sets; it clears only on reset. The transaction keeps waiting.
  - On the mem_ack_i cycle, the granted port's pX_ack_o=1 combinationally (mem_ack_i & BUSY & grant match); the other port's ack stays 0.
  - On that edge: mem_enable_o=0, mem_write_o=0, rr_ptr=~grant_o, go to TURN.
- Requester drops enable while BUSY (protocol violation): the transaction still completes and the ack is still pulsed.
- TURN: mem_enable_o stays low for exactly one cycle; requests are ignored; next state is IDLE. This guarantees the memory sees an enable low→high edge per transaction.
- Back-to-back on one port (e.g. dcache writeback then refill with enable held high): the port is re-granted via IDLE if the other port is idle.
- Contention after port 0 completes: port 1 wins the next arbitration because rr_ptr has moved.
- Minimum spacing between ack and next mem_enable_o rise: 2 cycles (TURN, IDLE).
- mem_ack_i outside BUSY is ignored; no port acks.
- pX_data_o is driven by mem_data_i to both ports at all times. It is valid only with that port's ack.
- busy_o=1 iff state==BUSY.

Test Plan:
- Single read, port 0 only: p0_enable_i=1, write=0, addr=0x00000400; memory acks 10 cycles after mem_enable_o.
  → mem_enable_o rises 1 cycle after the request, mem_addr_o=0x400, mem_write_o=0.
  → p0_ack_o pulses 1 cycle with p0_data_o=mem_data_i; p1_ack_o stays 0.
- Simultaneous requests after reset: p0 addr=0x100, p1 addr=0x200.
  → port 0 is served first (mem_addr_o=0x100); TURN cycle with mem_enable_o=0.
  → port 1 is served next (mem_addr_o=0x200, grant_o=1).
- Fairness: both ports hold enable continuously for 4 transactions.
  → grant order is 0,1,0,1; each ack goes only to the granted port.
- Writeback then refill on port 0, enable held: write addr=0x1420, data=256'hA5..A5, then read addr=0x0420.
  → mem_write_o=1 with that data on the first transaction; mem_enable_o low ≥1 cycle after the ack.
  → the second transaction has mem_write_o=0 and mem_addr_o=0x0420.
- Watchdog: TIMEOUT=64, memory never acks.
  → timeout_o=1 exactly 64 cycles after mem_enable_o rises; busy_o stays 1.
  → a late ack at cycle 80 still pulses the granted ack; timeout_o stays 1.
- Reset mid-BUSY: rst_i pulsed at cycle 5 of a transaction.
  → all outputs go to 0 immediately, with no ack.
  → after release, a pending p1 request is granted in the next cycle with rr_ptr=0 semantics.
